// File: rtl/counter_pkg.sv
// Shared constants and the limit-normalisation helper for the BCD digit counter bank.
package counter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // A limit of 0 or a non-BCD nibble means "count the full decade".
  function automatic logic [DIGIT_W-1:0] eff_limit(input logic [DIGIT_W-1:0] nibble);
    if (nibble == '0 || nibble > BCD_MAX) return BCD_MAX;
    return nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: adds step + carry_in (0..2) and wraps past `limit`.
// With DOWN_COUNT_EN defined it also subtracts dec + borrow_in and wraps below 0.
module bcd_digit
  import counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic               carry_in,
  input  logic [DIGIT_W-1:0] limit,
`ifdef DOWN_COUNT_EN
  input  logic               dec,
  input  logic               borrow_in,
  output logic               borrow_out,
`endif
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  logic [1:0]         up_amt;
  logic [DIGIT_W:0]   up_sum;
  logic [DIGIT_W-1:0] nxt;
`ifdef DOWN_COUNT_EN
  logic [1:0]         dn_amt;
`endif

  always_comb begin
    up_amt    = {1'b0, step} + {1'b0, carry_in};
    up_sum    = {1'b0, value} + {3'b000, up_amt};
    nxt       = value;
    carry_out = 1'b0;
`ifdef DOWN_COUNT_EN
    dn_amt     = {1'b0, dec} + {1'b0, borrow_in};
    borrow_out = 1'b0;
`endif
    if (up_amt != 2'd0) begin
      // A value above a freshly lowered limit restarts from zero.
      if (value > limit) begin
        nxt = '0;
      end else if (up_sum > {1'b0, limit}) begin
        nxt       = DIGIT_W'(up_sum - {1'b0, limit} - 5'd1);
        carry_out = 1'b1;
      end else begin
        nxt = up_sum[DIGIT_W-1:0];
      end
    end
`ifdef DOWN_COUNT_EN
    else if (dn_amt != 2'd0) begin
      if (value > limit) begin
        nxt = limit;
      end else if (value < {2'b00, dn_amt}) begin
        nxt        = DIGIT_W'({1'b0, value} + {1'b0, limit} + 5'd1 - {3'b000, dn_amt});
        borrow_out = 1'b1;
      end else begin
        nxt = value - {2'b00, dn_amt};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || clear) value <= '0;
    else                value <= nxt;
  end

endmodule

// File: rtl/digit_counter_bank.sv
// Bank of DIGITS edge-triggered BCD counters: single-digit, cascaded-carry or programmable-limit modes.
// Optional down counting (dec/underflow) is built when DOWN_COUNT_EN is defined.
module digit_counter_bank
  import counter_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGITS-1:0]         inc,
  input  logic                      clear,
  input  logic                      carry_en,
  input  logic                      max_en,
  input  logic [DIGIT_W*DIGITS-1:0] max_in,
`ifdef DOWN_COUNT_EN
  input  logic [DIGITS-1:0]         dec,
  output logic                      underflow,
`endif
  output logic [DIGIT_W*DIGITS-1:0] cnt_out,
  output logic                      overflow
);

  logic [DIGITS-1:0] inc_q;
  logic [DIGITS-1:0] step;
  logic              max_mode;

  // inc_q resets to all-ones so a level held high through reset is not an edge.
  assign step     = inc & ~inc_q;
  assign max_mode = max_en & ~carry_en;

`ifdef DOWN_COUNT_EN
  logic [DIGITS-1:0] dec_q;
  logic [DIGITS-1:0] dec_step;
  // Any up edge in the cycle wins over every down edge.
  assign dec_step = (|step) ? '0 : (dec & ~dec_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q <= '1;
`ifdef DOWN_COUNT_EN
      dec_q <= '1;
`endif
    end else begin
      inc_q <= inc;
`ifdef DOWN_COUNT_EN
      dec_q <= dec;
`endif
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic               cin;
    logic               cout;
    logic [DIGIT_W-1:0] lim;
`ifdef DOWN_COUNT_EN
    logic               bin;
    logic               bout;
`endif

    // Carries (and borrows) only cross into digit i when its link flag max_in[4i] is set.
    if (i == 0) begin : g_head
      assign cin = 1'b0;
`ifdef DOWN_COUNT_EN
      assign bin = 1'b0;
`endif
    end else begin : g_link
      assign cin = carry_en & g_dig[i-1].cout & max_in[DIGIT_W*i];
`ifdef DOWN_COUNT_EN
      assign bin = carry_en & g_dig[i-1].bout & max_in[DIGIT_W*i];
`endif
    end

    assign lim = max_mode ? eff_limit(max_in[DIGIT_W*i +: DIGIT_W]) : BCD_MAX;

    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .step      (step[i]),
      .carry_in  (cin),
      .limit     (lim),
`ifdef DOWN_COUNT_EN
      .dec       (dec_step[i]),
      .borrow_in (bin),
      .borrow_out(bout),
`endif
      .value     (cnt_out[DIGIT_W*i +: DIGIT_W]),
      .carry_out (cout)
    );
  end

  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= carry_en & ~clear & g_dig[DIGITS-1].cout;
  end

`ifdef DOWN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) underflow <= 1'b0;
    else       underflow <= carry_en & ~clear & g_dig[DIGITS-1].bout;
  end
`endif

endmodule

// File: tb/tb_digit_counter_bank.sv
// Self-checking bench for digit_counter_bank: vector table, corner sequences and random stimulus
// against a decimal-arithmetic reference model. Exercises dec/underflow when DOWN_COUNT_EN is defined.
module tb_digit_counter_bank;

  localparam int DIGITS = 6;
  localparam int W      = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              carry_en;
  logic              max_en;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] dec;
  logic [W-1:0]      max_in;
  logic [W-1:0]      cnt_out;
  logic              overflow;
`ifdef DOWN_COUNT_EN
  logic              underflow;
`endif

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  digit_counter_bank #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .clear    (clear),
    .carry_en (carry_en),
    .max_en   (max_en),
    .max_in   (max_in),
`ifdef DOWN_COUNT_EN
    .dec      (dec),
    .underflow(underflow),
`endif
    .cnt_out  (cnt_out),
    .overflow (overflow)
  );

  // ---------------- reference model ----------------
  int                md[DIGITS];
  logic [DIGITS-1:0] m_inc_prev;
  logic [DIGITS-1:0] m_dec_prev;
  logic              m_ovf;
  logic              m_unf;

  function automatic int lim_of(input logic [3:0] n);
    if (n == 4'd0 || n > 4'd9) return 9;
    return int'(n);
  endfunction

  function automatic logic [W-1:0] model_pack();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(md[i]);
    return r;
  endfunction

  // One clock edge of the behaviour, computed with plain decimal arithmetic.
  task automatic model_step();
    logic [DIGITS-1:0] up;
    logic [DIGITS-1:0] dn;
    int c;
    int v;
    int l;
    up = inc & ~m_inc_prev;
    dn = dec & ~m_dec_prev;
    m_inc_prev = inc;
    m_dec_prev = dec;
`ifndef DOWN_COUNT_EN
    dn = '0;
`endif
    if (up != '0) dn = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (clear) begin
      for (int i = 0; i < DIGITS; i++) md[i] = 0;
    end else if (carry_en) begin
      c = 0;  // +1 carry, -1 borrow travelling upward
      for (int i = 0; i < DIGITS; i++) begin
        v = md[i] + int'(up[i]) - int'(dn[i]);
        if (i > 0 && max_in[4*i]) v = v + c;
        if (v > 9)      begin v = v - 10; c = 1;  end
        else if (v < 0) begin v = v + 10; c = -1; end
        else c = 0;
        md[i] = v;
      end
      m_ovf = (c == 1);
      m_unf = (c == -1);
    end else if (max_en) begin
      for (int i = 0; i < DIGITS; i++) begin
        l = lim_of(max_in[4*i +: 4]);
        if (up[i]) md[i] = (md[i] >= l) ? 0 : md[i] + 1;
        if (dn[i]) md[i] = (md[i] == 0 || md[i] > l) ? l : md[i] - 1;
      end
    end else begin
      for (int i = 0; i < DIGITS; i++)
        md[i] = (md[i] + int'(up[i]) - int'(dn[i]) + 10) % 10;
    end
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_cnt", cnt_out, model_pack());
    chk("model_ovf", W'(overflow), W'(m_ovf));
`ifdef DOWN_COUNT_EN
    chk("model_unf", W'(underflow), W'(m_unf));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [DIGITS-1:0] i_inc, input logic clr,
                     input logic [DIGITS-1:0] i_dec = '0);
    inc   = i_inc;
    dec   = i_dec;
    clear = clr;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pulse(input logic [DIGITS-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(mask, 1'b0);
      cyc('0, 1'b0);
    end
  endtask

  task automatic set_mode(input logic c_en, input logic m_en, input logic [W-1:0] mx);
    carry_en = c_en;
    max_en   = m_en;
    max_in   = mx;
  endtask

  typedef struct {
    logic [DIGITS-1:0] inc;
    logic              clr;
    logic [W-1:0]      exp_cnt;
    logic              exp_ovf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Max mode, digit 0 limit 3, digit 1 limit 0 (treated as 9).
    tbl[0]  = '{6'h01, 1'b0, 24'h000001, 1'b0};
    tbl[1]  = '{6'h00, 1'b0, 24'h000001, 1'b0};
    tbl[2]  = '{6'h01, 1'b0, 24'h000002, 1'b0};
    tbl[3]  = '{6'h00, 1'b0, 24'h000002, 1'b0};
    tbl[4]  = '{6'h01, 1'b0, 24'h000003, 1'b0};
    tbl[5]  = '{6'h00, 1'b0, 24'h000003, 1'b0};
    tbl[6]  = '{6'h01, 1'b0, 24'h000000, 1'b0};
    tbl[7]  = '{6'h00, 1'b0, 24'h000000, 1'b0};
    tbl[8]  = '{6'h03, 1'b0, 24'h000011, 1'b0};
    tbl[9]  = '{6'h00, 1'b1, 24'h000000, 1'b0};
    tbl[10] = '{6'h03, 1'b1, 24'h000000, 1'b0};
    tbl[11] = '{6'h00, 1'b0, 24'h000000, 1'b0};
    tbl[12] = '{6'h02, 1'b0, 24'h000010, 1'b0};

    reset = 1'b1;
    inc   = '1;
    dec   = '1;
    clear = 1'b0;
    set_mode(1'b0, 1'b0, '0);
    for (int i = 0; i < DIGITS; i++) md[i] = 0;
    m_inc_prev = '1;
    m_dec_prev = '1;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // Reset with inc held high: nothing counts until inc falls and rises.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cnt", cnt_out, '0);
    chk("reset_ovf", W'(overflow), '0);
    reset = 1'b0;
    cyc('1, 1'b0, '1);
    chk("held_inc_no_count", cnt_out, '0);
    cyc('0, 1'b0);
    cyc(6'h01, 1'b0);
    chk("first_edge_counts", cnt_out, 24'h000001);
    cyc('0, 1'b1);

    // Table-driven vectors in max mode.
    set_mode(1'b0, 1'b1, 24'h000003);
    for (int k = 0; k < 13; k++) begin
      cyc(tbl[k].inc, tbl[k].clr);
      chk($sformatf("tbl%0d_cnt", k), cnt_out, tbl[k].exp_cnt);
      chk($sformatf("tbl%0d_ovf", k), W'(overflow), W'(tbl[k].exp_ovf));
    end

    // Digit 1 with limit nibble 0 wraps at 9.
    cyc('0, 1'b1);
    pulse(6'h02, 9);
    chk("max_d1_at9", cnt_out, 24'h000090);
    pulse(6'h02, 1);
    chk("max_d1_wrap", cnt_out, 24'h000000);

    // Single mode: ten edges on digit 0 wrap without carry.
    set_mode(1'b0, 1'b0, 24'h111111);
    pulse(6'h01, 10);
    chk("single_wrap", cnt_out, 24'h000000);

    // Carry mode: full ripple from 999999 with overflow pulse.
    pulse('1, 9);
    chk("preset_999999", cnt_out, 24'h999999);
    set_mode(1'b1, 1'b0, 24'h111111);
    cyc(6'h01, 1'b0);
    chk("ripple_cnt", cnt_out, 24'h000000);
    chk("ripple_ovf", W'(overflow), W'(1'b1));
    cyc('0, 1'b0);
    chk("ovf_one_cycle", W'(overflow), '0);

    // Broken link into digit 2 stops the ripple.
    set_mode(1'b0, 1'b0, 24'h111011);
    pulse('1, 9);
    carry_en = 1'b1;
    cyc(6'h01, 1'b0);
    chk("broken_link_cnt", cnt_out, 24'h999900);
    chk("broken_link_ovf", W'(overflow), '0);
    cyc('0, 1'b0);

    // Simultaneous edges with ripple: 89 + step0 + step1 -> 100.
    cyc('0, 1'b1);
    set_mode(1'b0, 1'b0, 24'h111111);
    pulse(6'h03, 8);
    pulse(6'h01, 1);
    chk("preset_89", cnt_out, 24'h000089);
    carry_en = 1'b1;
    cyc(6'h03, 1'b0);
    chk("double_step_cnt", cnt_out, 24'h000100);
    cyc('0, 1'b0);

    // Clear during a would-be overflow edge.
    cyc('0, 1'b1);
    carry_en = 1'b0;
    pulse('1, 9);
    carry_en = 1'b1;
    cyc(6'h01, 1'b1);
    chk("clear_cnt", cnt_out, '0);
    chk("clear_no_ovf", W'(overflow), '0);
    cyc('0, 1'b0);

    // Limit lowered below the current value: next step gives 0.
    set_mode(1'b0, 1'b0, '0);
    pulse(6'h01, 7);
    set_mode(1'b0, 1'b1, 24'h000005);
    cyc(6'h01, 1'b0);
    chk("lowered_limit", cnt_out, 24'h000000);
    cyc('0, 1'b0);

`ifdef DOWN_COUNT_EN
    cyc('0, 1'b1, '0);
    cyc('0, 1'b0, 6'h01);
    chk("dec_max_wrap", cnt_out, 24'h000005);
    cyc('0, 1'b1, '0);
    set_mode(1'b1, 1'b0, 24'h111111);
    cyc('0, 1'b0, 6'h01);
    chk("borrow_cnt", cnt_out, 24'h999999);
    chk("borrow_unf", W'(underflow), W'(1'b1));
    cyc('0, 1'b0, '0);
    cyc(6'h01, 1'b0, 6'h02);
    chk("inc_beats_dec", cnt_out, 24'h000000);
    cyc('0, 1'b0, '0);
`endif

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      if (n % 25 == 0)
        set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom()));
      cyc(DIGITS'($urandom()) & DIGITS'($urandom()),
          $urandom_range(0, 29) == 0,
          DIGITS'($urandom()) & DIGITS'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
